// File: rtl/nes_pad_poller.sv
// nes_pad_poller: polls PLAYERS serial game pads over a shared latch/pulse pair and
// publishes each complete frame atomically. Define NES_PRESS_EDGE_EN to build the `pressed` edge mask.
module nes_pad_poller #(
   parameter int PLAYERS     = 2,
   parameter int BITS        = 8,
   parameter int HALF_CYCLES = 300,
   parameter int POLL_CYCLES = 833333
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    auto_en,
   input  logic [PLAYERS-1:0]      data,
   output logic                    latch,
   output logic                    pulse,
   output logic                    busy,
   output logic                    valid,
   output logic [PLAYERS*BITS-1:0] buttons,
   output logic [PLAYERS*BITS-1:0] pressed
);
   localparam int WIDTH   = PLAYERS * BITS;
   localparam int PHASE_W = $clog2(2 * HALF_CYCLES);
   localparam int BIT_W   = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int POLL_W  = $clog2(POLL_CYCLES);

   localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_CYCLES - 1);
   localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);
   localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS - 1);
   localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

   state_t             state;
   logic [PHASE_W-1:0] phase;
   logic [BIT_W-1:0]   bit_idx;
   logic [POLL_W-1:0]  timer;
   logic               pending;
   logic [PLAYERS-1:0] data_s1;
   logic [PLAYERS-1:0] data_s2;
   logic [WIDTH-1:0]   shift;
   logic [WIDTH-1:0]   shift_next;
   logic               tick;
   logic               request;
   logic               frame_end;

   // NOTE: pad lines are asynchronous to clock; they only reach the shift
   // registers through two flops, so they need no reset.
   always_ff @(posedge clock) begin
      data_s1 <= data;
      data_s2 <= data_s1;
   end

   always_ff @(posedge clock) begin
      if (reset || !auto_en)
         timer <= '0;
      else if (timer == POLL_LAST)
         timer <= '0;
      else
         timer <= timer + 1'b1;
   end

   assign tick      = auto_en && (timer == POLL_LAST);
   assign request   = start || tick;
   assign frame_end = (state == LOW) && (phase == HALF_LAST) && (bit_idx == BIT_LAST);

   // Shift image including the bit captured this cycle, so DONE can publish it in one step.
   // NOTE: every variable written here gets its default first, which keeps the block latch-free.
   always_comb begin
      shift_next = shift;
      for (int p = 0; p < PLAYERS; p++)
         shift_next[p*BITS + int'(bit_idx)] = ~data_s2[p];
   end

   // NOTE: sequential state uses non-blocking assignments only; the shift
   // registers are reset like the rest so a fresh frame never inherits old data.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         phase   <= '0;
         bit_idx <= '0;
         pending <= 1'b0;
         latch   <= 1'b0;
         pulse   <= 1'b0;
         busy    <= 1'b0;
         valid   <= 1'b0;
         shift   <= '0;
         buttons <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // The DONE cycle is already idle from the outside, so a pending request starts here.
               if (request || pending) begin
                  state   <= LATCH;
                  latch   <= 1'b1;
                  busy    <= 1'b1;
                  phase   <= '0;
                  bit_idx <= '0;
                  pending <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            LATCH: begin
               pending <= pending || request;
               if (phase == LATCH_LAST) begin
                  state <= LOW;
                  latch <= 1'b0;
                  phase <= '0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            LOW: begin
               pending <= pending || request;
               if (phase == HALF_LAST) begin
                  shift <= shift_next;
                  phase <= '0;
                  if (bit_idx == BIT_LAST) begin
                     state   <= DONE;
                     buttons <= shift_next;
                     valid   <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     state   <= HIGH;
                     pulse   <= 1'b1;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            HIGH: begin
               pending <= pending || request;
               if (phase == HALF_LAST) begin
                  state <= LOW;
                  pulse <= 1'b0;
                  phase <= '0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               latch <= 1'b0;
               pulse <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef NES_PRESS_EDGE_EN
   // buttons still holds the previous frame on the publishing edge.
   always_ff @(posedge clock) begin
      if (reset)
         pressed <= '0;
      else if (frame_end)
         pressed <= shift_next & ~buttons;
   end
`else
   assign pressed = '0;
`endif

endmodule

// File: tb/tb_nes_pad_poller.sv
// Scoreboard bench for nes_pad_poller: a pad model serves random/directed frames,
// a monitor checks timing and frame contents whenever valid is presented.
module tb_nes_pad_poller;
   localparam int PLAYERS = 2;
   localparam int BITS    = 8;
   localparam int HALF    = 4;
   localparam int POLL    = 200;
   localparam int W       = PLAYERS * BITS;

   logic               clock   = 1'b0;
   logic               reset   = 1'b1;
   logic               start   = 1'b0;
   logic               auto_en = 1'b0;
   logic [PLAYERS-1:0] data    = '1;
   logic               latch, pulse, busy, valid;
   logic [W-1:0]       buttons, pressed;

   nes_pad_poller #(
      .PLAYERS(PLAYERS), .BITS(BITS), .HALF_CYCLES(HALF), .POLL_CYCLES(POLL)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .auto_en(auto_en), .data(data),
      .latch(latch), .pulse(pulse), .busy(busy), .valid(valid),
      .buttons(buttons), .pressed(pressed)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] dir_q[$];
   logic [W-1:0] prev_btn = '0;
   longint     cyc = 0;
   longint     rise_t = 0;
   longint     valid_t = -1000;
   longint     gap = -1;
   longint     pulse_rise_t = 0;
   int         rises = 0;
   int         valids = 0;
   int         pulses = 0;
   bit         in_frame = 0;
   logic       p_latch = 0, p_pulse = 0, p_valid = 0;
   logic       pm_latch = 0, pm_pulse = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pad model: picks the frame content at the latch rise and shifts one bit per pulse rise.
   initial begin
      int idx;
      logic [W-1:0] cur;
      idx = BITS;
      cur = '0;
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            idx = BITS;
         end else if (latch && !pm_latch) begin
            if (dir_q.size() > 0) cur = dir_q.pop_front();
            else                  cur = W'($urandom);
            exp_q.push_back(cur);
            idx = 0;
         end else if (pulse && !pm_pulse) begin
            idx++;
         end
         pm_latch = latch;
         pm_pulse = pulse;
         for (int p = 0; p < PLAYERS; p++)
            data[p] = (idx < BITS) ? ~cur[p*BITS + idx] : 1'b1;
      end
   end

   // Monitor: frame timing and scoreboard comparison on every valid.
   initial begin
      logic [W-1:0] e;
      logic [W-1:0] exp_p;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (reset) begin
            in_frame = 0;
            prev_btn = '0;
         end else begin
            if (latch && !p_latch) begin
               rises++;
               gap      = cyc - valid_t;
               rise_t   = cyc;
               in_frame = 1;
               pulses   = 0;
               check("busy_at_latch", busy, 1);
            end
            if (!latch && p_latch && in_frame)
               check("latch_width", cyc - rise_t, 2 * HALF);
            if (pulse && !p_pulse) begin
               pulses++;
               pulse_rise_t = cyc;
               if (pulses == 1) check("first_pulse", cyc - rise_t, 3 * HALF);
            end
            if (!pulse && p_pulse && in_frame)
               check("pulse_width", cyc - pulse_rise_t, HALF);
            if (valid) begin
               valids++;
               valid_t = cyc;
               check("valid_one_cycle", p_valid, 0);
               check("busy_at_valid", busy, 0);
               if (in_frame) begin
                  check("valid_latency", cyc - rise_t, (2 * BITS + 1) * HALF);
                  check("pulse_count", pulses, BITS - 1);
               end
               in_frame = 0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid: got buttons 0x%0h with no frame expected", buttons);
               end else begin
                  e = exp_q.pop_front();
                  check("buttons", buttons, e);
`ifdef NES_PRESS_EDGE_EN
                  exp_p = e & ~prev_btn;
`else
                  exp_p = '0;
`endif
                  check("pressed", pressed, exp_p);
                  prev_btn = e;
               end
            end
         end
         p_latch = latch;
         p_pulse = pulse;
         p_valid = valid;
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_valids(input int target, input int budget, input string name);
      int n = 0;
      while (valids < target && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, valids, target);
   endtask

   task automatic wait_rises(input int target, input int budget, input string name);
      int n = 0;
      while (rises < target && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, rises, target);
   endtask

   task automatic do_reset(input int n);
      @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      repeat (n) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, v0, n_frames;
      bit nz;
      longint t[4];

      // Reset held 3 cycles, then idle with start low.
      repeat (3) @(negedge clock);
      reset = 1'b0;
      r0 = rises;
      nz = 0;
      repeat (300) begin
         @(posedge clock);
         #2;
         if (latch || pulse || busy || valid || buttons != '0 || pressed != '0) nz = 1;
      end
      check("idle_outputs_zero", nz, 0);
      check("idle_no_latch", rises, r0);

      // Directed frame: pad0 bits 0 and 7 pressed, pad1 released.
      v0 = valids;
      dir_q.push_back(16'h0081);
      pulse_start();
      wait_valids(v0 + 1, 200, "t2_frame_done");
      check("t2_buttons", buttons, 16'h0081);

      // Two extra starts during a frame coalesce into one back-to-back frame.
      v0 = valids;
      r0 = rises;
      pulse_start();
      tick_n(30);
      pulse_start();
      tick_n(10);
      pulse_start();
      wait_valids(v0 + 2, 400, "t3_two_frames");
      check("t3_back_to_back_gap", gap, 1);
      tick_n(200);
      check("t3_frame_count", rises - r0, 2);

      // Periodic polling.
      r0 = rises;
      @(negedge clock);
      auto_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_rises(r0 + i + 1, 300, "t4_auto_latch");
         t[i] = rise_t;
      end
      for (int i = 1; i < 4; i++) check("t4_poll_period", t[i] - t[i-1], POLL);
      v0 = valids;
      wait_valids(v0 + 1, 100, "t4_last_frame");
      auto_en = 1'b0;
      r0 = rises;
      tick_n(500);
      check("t4_disabled_no_frames", rises, r0);

      // Reset during bit 4 aborts the frame.
      v0 = valids;
      r0 = rises;
      pulse_start();
      wait_rises(r0 + 1, 20, "t5_latch_rise");
      begin
         int n = 0;
         while (pulses < 4 && n < 100) begin
            @(negedge clock);
            n++;
         end
      end
      check("t5_reached_bit4", pulses, 4);
      tick_n(2);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clock);
      #2;
      check("t5_latch_cleared", latch, 0);
      check("t5_pulse_cleared", pulse, 0);
      check("t5_buttons_cleared", buttons, 0);
      check("t5_valid_low", valid, 0);
      @(negedge clock);
      reset = 1'b0;
      tick_n(100);
      check("t5_no_valid", valids, v0);
      pulse_start();
      wait_valids(v0 + 1, 200, "t5_clean_frame");

      // Newly-pressed mask over two directed frames.
      do_reset(2);
      v0 = valids;
      dir_q.push_back(16'h0001);
      dir_q.push_back(16'h0003);
      pulse_start();
      wait_valids(v0 + 1, 200, "t6_frame1");
`ifdef NES_PRESS_EDGE_EN
      check("t6_pressed1", pressed[7:0], 8'h01);
`else
      check("t6_pressed1", pressed[7:0], 8'h00);
`endif
      pulse_start();
      wait_valids(v0 + 2, 200, "t6_frame2");
`ifdef NES_PRESS_EDGE_EN
      check("t6_pressed2", pressed[7:0], 8'h02);
`else
      check("t6_pressed2", pressed[7:0], 8'h00);
`endif

      // Random frames, some with an extra mid-frame request.
      for (int i = 0; i < 6; i++) begin
         v0 = valids;
         r0 = rises;
         pulse_start();
         n_frames = 1;
         if ($urandom_range(0, 1) == 1) begin
            tick_n($urandom_range(5, 50));
            pulse_start();
            n_frames = 2;
         end
         wait_valids(v0 + n_frames, 400, "rand_frames");
         check("rand_frame_count", rises - r0, n_frames);
         tick_n($urandom_range(1, 20));
      end

      tick_n(5);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
